counter_dispatch: RTL and testbench

COUNTER_DISPATCH -- requirements
Module: counter_dispatch

---
 rtl/counter_dispatch.sv | 109 ++++++++++
 tb/tb_counter_dispatch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_dispatch.sv
// Service-counter dispatcher: pulls customers from a FIFO head into the lowest idle counter
// and counts each counter's service time down on tick strobes.
module counter_dispatch #(
  parameter int unsigned DT_SZ = 4,
  parameter int unsigned NCNT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  q_empty,
  input  logic [DT_SZ-1:0]      q_qn,
  input  logic [DT_SZ-1:0]      q_qt,
  output logic                  q_re,
  output logic [NCNT-1:0]       busy,
  output logic [NCNT*DT_SZ-1:0] cnum,
  output logic [NCNT*DT_SZ-1:0] crem,
  output logic [NCNT-1:0]       done,
  output logic [7:0]            served
);

  localparam logic StIdle  = 1'b0;
  localparam logic StServe = 1'b1;

  logic [NCNT-1:0]  state_q, state_d;
  logic [NCNT-1:0]  done_q, done_d;
  logic [NCNT-1:0]  load_en;
  logic [DT_SZ-1:0] cnum_q [NCNT];
  logic [DT_SZ-1:0] cnum_d [NCNT];
  logic [DT_SZ-1:0] crem_q [NCNT];
  logic [DT_SZ-1:0] crem_d [NCNT];
  logic [7:0]       served_q, served_d;
  logic [DT_SZ-1:0] load_t;
  logic             found;

  // Held low through reset so the FIFO never pops while we are discarding state.
  assign q_re   = rst_n & ~q_empty & (|(~state_q));
  assign load_t = (q_qt == '0) ? DT_SZ'(1) : q_qt;

  always_comb begin
    load_en = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(NCNT); k++) begin
      if (state_q[k] == StIdle && !found) begin
        load_en[k] = q_re;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = '0;
    served_d = served_q;
    for (int k = 0; k < int'(NCNT); k++) begin
      cnum_d[k] = cnum_q[k];
      crem_d[k] = crem_q[k];
      if (state_q[k] == StServe) begin
        if (tick) begin
          if (crem_q[k] > DT_SZ'(1)) begin
            crem_d[k] = crem_q[k] - DT_SZ'(1);
          end else begin
            crem_d[k]  = '0;
            state_d[k] = StIdle;
            done_d[k]  = 1'b1;
          end
        end
      end else if (load_en[k]) begin
        state_d[k] = StServe;
        cnum_d[k]  = q_qn;
        crem_d[k]  = load_t;
      end
      served_d = served_d + 8'(done_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      done_q   <= '0;
      served_q <= '0;
      for (int k = 0; k < int'(NCNT); k++) begin
        cnum_q[k] <= '0;
        crem_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      served_q <= served_d;
      for (int k = 0; k < int'(NCNT); k++) begin
        cnum_q[k] <= cnum_d[k];
        crem_q[k] <= crem_d[k];
      end
    end
  end

  always_comb begin
    cnum = '0;
    crem = '0;
    for (int k = 0; k < int'(NCNT); k++) begin
      cnum[k*DT_SZ +: DT_SZ] = cnum_q[k];
      crem[k*DT_SZ +: DT_SZ] = crem_q[k];
    end
  end

  assign busy   = state_q;
  assign done   = done_q;
  assign served = served_q;

endmodule

// File: tb/tb_counter_dispatch.sv
// Scoreboard bench for counter_dispatch: a queue-based customer model drives the FIFO and
// predicts every counter; a separate monitor retires expected completions on done pulses.
module tb_counter_dispatch;

  localparam int unsigned DT_SZ = 4;
  localparam int unsigned NCNT  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  tick;
  logic                  q_empty;
  logic [DT_SZ-1:0]      q_qn, q_qt;
  logic                  q_re;
  logic [NCNT-1:0]       busy;
  logic [NCNT*DT_SZ-1:0] cnum, crem;
  logic [NCNT-1:0]       done;
  logic [7:0]            served;

  counter_dispatch #(.DT_SZ(DT_SZ), .NCNT(NCNT)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .q_empty(q_empty), .q_qn(q_qn), .q_qt(q_qt),
    .q_re(q_re), .busy(busy), .cnum(cnum), .crem(crem), .done(done), .served(served)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] n; logic [3:0] t;} cust_t;
  typedef struct packed {logic [1:0] k; logic [3:0] num;} exp_t;

  cust_t      fifo[$];
  exp_t       sb[$];
  logic [3:0] mnum [2];
  logic [3:0] mrem [2];
  logic [1:0] mbusy, mdone;
  logic [7:0] mserved;
  logic       mq_re;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mnum[k] = '0;
      mrem[k] = '0;
    end
    mbusy   = '0;
    mdone   = '0;
    mserved = '0;
    fifo.delete();
    sb.delete();
  endtask

  // One clock: compare state at negedge, drive inputs, check q_re, then advance the model.
  task automatic do_cycle(input int tick_mode);
    logic       tv;
    logic [1:0] pre_busy;
    logic       placed;
    @(negedge clk);
    check("busy", busy, mbusy);
    check("crem", crem, {mrem[1], mrem[0]});
    check("cnum", cnum, {mnum[1], mnum[0]});
    check("served", served, mserved);
    check("done", done, mdone);
    if (tick_mode == 2) begin
      tv = ($urandom_range(0, 9) < 7);
      if (fifo.size() < 4 && $urandom_range(0, 2) == 0)
        fifo.push_back('{n: 4'($urandom_range(0, 15)), t: 4'($urandom_range(0, 5))});
    end else begin
      tv = (tick_mode == 1);
    end
    tick = tv;
    if (fifo.size() > 0) begin
      q_empty = 1'b0;
      q_qn    = fifo[0].n;
      q_qt    = fifo[0].t;
    end else begin
      q_empty = 1'b1;
      q_qn    = 4'($urandom);
      q_qt    = 4'($urandom);
    end
    #1;
    mq_re = (fifo.size() > 0) && (mbusy != 2'b11);
    check("q_re", q_re, mq_re);
    @(posedge clk);
    pre_busy = mbusy;
    mdone    = '0;
    if (tv) begin
      for (int k = 0; k < 2; k++) begin
        if (pre_busy[k]) begin
          if (mrem[k] > 1) mrem[k] = mrem[k] - 1;
          else begin
            mrem[k]  = '0;
            mbusy[k] = 1'b0;
            mdone[k] = 1'b1;
            mserved  = mserved + 1;
          end
        end
      end
    end
    if (mq_re) begin
      placed = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (!placed && !pre_busy[k]) begin
          placed   = 1'b1;
          mnum[k]  = fifo[0].n;
          mrem[k]  = (fifo[0].t == 0) ? 4'd1 : fifo[0].t;
          mbusy[k] = 1'b1;
          sb.push_back('{k: 2'(k), num: fifo[0].n});
        end
      end
      void'(fifo.pop_front());
    end
  endtask

  task automatic run(input int n, input int tick_mode);
    for (int i = 0; i < n; i++) do_cycle(tick_mode);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n   = 1'b0;
    tick    = 1'b1;
    q_empty = 1'b0;
    q_qn    = 4'd9;
    q_qt    = 4'd9;
    #1;
    check("rst_busy", busy, 0);
    check("rst_cnum", cnum, 0);
    check("rst_crem", crem, 0);
    check("rst_done", done, 0);
    check("rst_served", served, 0);
    check("rst_q_re", q_re, 0);
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    tick    = 1'b0;
    q_empty = 1'b1;
  endtask

  // Monitor: every done pulse must retire a customer dispatched to that counter.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].k == 2'(k)) idx = i;
          if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_done: counter %0d got done, expected none", k);
          end else begin
            check("sb_cnum", cnum[k*DT_SZ +: DT_SZ], sb[idx].num);
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    tick    = 1'b0;
    q_empty = 1'b1;
    q_qn    = '0;
    q_qt    = '0;
    model_reset();
    reset_dut();

    fifo.push_back('{n: 4'd5, t: 4'd3});
    run(6, 1);
    @(negedge clk);
    check("single_served", served, 1);

    fifo.push_back('{n: 4'd1, t: 4'd4});
    fifo.push_back('{n: 4'd2, t: 4'd2});
    fifo.push_back('{n: 4'd3, t: 4'd1});
    run(12, 1);

    reset_dut();
    fifo.push_back('{n: 4'd1, t: 4'd2});
    fifo.push_back('{n: 4'd2, t: 4'd1});
    run(5, 1);
    @(negedge clk);
    check("simul_served", served, 2);

    fifo.push_back('{n: 4'd7, t: 4'd0});
    run(4, 1);

    fifo.push_back('{n: 4'd4, t: 4'd5});
    run(1, 0);
    fifo.push_back('{n: 4'd6, t: 4'd3});
    run(10, 0);
    @(negedge clk);
    check("gate_crem", crem, {4'd3, 4'd5});
    run(12, 1);

    fifo.push_back('{n: 4'd1, t: 4'd9});
    fifo.push_back('{n: 4'd2, t: 4'd9});
    run(3, 1);
    @(negedge clk);
    check("mid_busy", busy, 2'b11);
    reset_dut();
    run(5, 1);

    run(400, 2);
    for (int i = 0; i < 200; i++)
      if (mbusy != 0 || fifo.size() > 0) do_cycle(1);
    run(2, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
